// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty decoder and its divider.
package pwm_pkg;

    typedef enum logic {
        ARMED   = 1'b0,
        MEASURE = 1'b1
    } dec_state_t;

    localparam int DUTY_W    = 8;
    localparam int DIV_ITERS = 8;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, quot = floor(num*256/den) for num < den: start latches operands,
// 8 iteration cycles, done is high the cycle after the last iteration; a start then is accepted.
module seq_divider
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);

    localparam int IW = $clog2(DIV_ITERS + 1);

    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] den_r;
    logic [IW-1:0]    iter;
    logic             run;
    logic             last;

    assign rem_sh = rem << 1;
    assign last   = (iter == IW'(DIV_ITERS));
    assign busy   = run && !last;
    assign done   = run && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            iter  <= '0;
            rem   <= '0;
            den_r <= '0;
            quot  <= '0;
        end else if (clear) begin
            run   <= 1'b0;
            iter  <= '0;
        end else if (start) begin
            run   <= 1'b1;
            iter  <= '0;
            rem   <= {1'b0, num};
            den_r <= den;
            quot  <= '0;
        end else if (busy) begin
            // Quotient bits shift in MSB first.
            if (rem_sh >= {1'b0, den_r}) begin
                rem  <= rem_sh - {1'b0, den_r};
                quot <= {quot[DUTY_W-2:0], 1'b1};
            end else begin
                rem  <= rem_sh;
                quot <= {quot[DUTY_W-2:0], 1'b0};
            end
            iter <= iter + 1'b1;
        end else if (done) begin
            run <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers 8-bit duty and period of an asynchronous PWM input; duty_valid 12 clk edges
// after the pin rise closing a period. A rise while the divider is busy drops the sample (overrun).
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic [CNT_W-1:0]  period,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    logic [1:0]        sync_q;
    logic              hist;
    logic              rise;
    logic              fall;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  high_lat;
    logic [CNT_W-1:0]  period_pend;
    dec_state_t        state;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
            hist   <= sync_q[1];
        end
    end

    assign rise = sync_q[1] && !hist;
    assign fall = !sync_q[1] && hist;

    assign div_start = en && (state == MEASURE) && rise && !div_busy;

    seq_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (!en),
        .start (div_start),
        .num   (high_lat),
        .den   (cnt),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARMED;
            cnt         <= '0;
            high_lat    <= '0;
            period_pend <= '0;
            duty        <= '0;
            duty_valid  <= 1'b0;
            period      <= '0;
            overrun     <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            overrun    <= 1'b0;

            if (div_done && en) begin
                duty       <= div_quot;
                period     <= period_pend;
                duty_valid <= 1'b1;
            end

            if (!en) begin
                state       <= ARMED;
                cnt         <= '0;
                high_lat    <= '0;
                period_pend <= '0;
            end else begin
                if (rise) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end

                if (fall) begin
                    high_lat <= cnt;
                end

                case (state)
                    ARMED: begin
                        if (rise) begin
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // The period is published together with the quotient it belongs to.
                        if (rise) begin
                            if (div_busy) begin
                                overrun <= 1'b1;
                            end else begin
                                period_pend <= cnt;
                            end
                        end else if (cnt == TO_VAL) begin
                            duty       <= sync_q[1] ? '1 : '0;
                            period     <= '0;
                            duty_valid <= 1'b1;
                            state      <= ARMED;
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed PWM waveforms; expected duty/period/latency queued at stimulus, checked by a monitor.
module tb_pwm_duty_decoder;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4096;

    typedef struct {
        logic [7:0] d;
        int         p;
        int         c;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic             pwm;
    logic [7:0]       duty;
    logic             duty_valid;
    logic [CNT_W-1:0] period;
    logic             overrun;

    exp_t exp_q[$];
    int   cyc;
    int   n_vec;
    int   n_err;
    int   n_ovr;

    pwm_duty_decoder #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm),
        .duty       (duty),
        .duty_valid (duty_valid),
        .period     (period),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every duty_valid must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && overrun) n_ovr++;
        if (!rst && duty_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got duty=%02h period=%0d at cycle %0d, required no duty_valid",
                         duty, period, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (duty !== e.d || period !== CNT_W'(e.p) || (e.c >= 0 && cyc != e.c)) begin
                    n_err++;
                    $display("FAIL sample: got duty=%02h period=%0d cycle=%0d, required duty=%02h period=%0d cycle=%0d",
                             duty, period, cyc, e.d, e.p, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int p, input int c);
        exp_t e;
        e.d = d;
        e.p = p;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // n periods of period p / high h; each rise after the first closes a period.
    // With ovr_alt, even-numbered closing rises hit a busy divider.
    task automatic burst(input int p, input int h, input int n, input logic [7:0] d, input bit ovr_alt);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pwm = 1'b1;
            if (k > 0) begin
                if (ovr_alt && (k % 2 == 0)) begin
                    // dropped sample
                end else begin
                    push_exp(d, p, cyc + 12);
                end
            end
            repeat (h) @(negedge clk);
            pwm = 1'b0;
            repeat (p - h - 1) @(negedge clk);
        end
    endtask

    task automatic en_toggle();
        repeat (20) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_ovr = 0;
        rst   = 1'b1;
        en    = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_duty", int'(duty), 0);
        check("reset_valid", int'(duty_valid), 0);
        check("reset_period", int'(period), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        en  = 1'b1;
        repeat (5) @(negedge clk);

        // 25% duty at 256 cycles, then static low -> timeout
        burst(256, 64, 20, 8'h40, 1'b0);
        push_exp(8'h00, 0, -1);
        repeat (5000) @(negedge clk);

        // 33/100, then static high: the rise closes one more period, then timeout
        burst(100, 33, 5, 8'h54, 1'b0);
        @(negedge clk);
        pwm = 1'b1;
        push_exp(8'h54, 100, cyc + 12);
        push_exp(8'hFF, 0, -1);
        repeat (5000) @(negedge clk);

        pwm = 1'b0;
        repeat (20) @(negedge clk);
        burst(300, 299, 3, 8'hFF, 1'b0);
        en_toggle();

        // Too-short period: alternate samples overrun
        burst(8, 4, 9, 8'h80, 1'b1);
        repeat (20) @(negedge clk);
        check("overrun_period8", n_ovr, 4);
        en_toggle();

        burst(10, 5, 6, 8'h80, 1'b0);
        repeat (20) @(negedge clk);
        check("overrun_period10", n_ovr, 4);
        en_toggle();

        // Reset during divider cycle 4
        burst(256, 64, 1, 8'h40, 1'b0);
        @(negedge clk);
        pwm = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        pwm = 1'b0;
        #1;
        check("rst_mid_duty", int'(duty), 0);
        check("rst_mid_valid", int'(duty_valid), 0);
        check("rst_mid_period", int'(period), 0);
        check("rst_mid_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        burst(256, 64, 3, 8'h40, 1'b0);
        en_toggle();

        // en dropped mid-divide: outputs hold, no valid
        burst(100, 33, 1, 8'h54, 1'b0);
        @(negedge clk);
        pwm = 1'b1;
        repeat (7) @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        pwm = 1'b0;
        check("en_hold_duty", int'(duty), 8'h40);
        check("en_hold_period", int'(period), 256);
        repeat (20) @(negedge clk);
        en = 1'b1;
        burst(100, 33, 3, 8'h54, 1'b0);

        repeat (40) @(negedge clk);
        check("pending_samples", exp_q.size(), 0);
        check("overrun_total", n_ovr, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
